frame_burst_writer: RTL and testbench
=====================================

FRAME_BURST_WRITER -- requirements
Module: frame_burst_writer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, meaning 128-bit beats per write burst (power of two, 2..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 64, meaning 128-bit word FIFO entries (power of two, at least 2*BURST_LEN).
REQ-003 SHALL have parameter FRAME_WORDS, default 115200, meaning 128-bit words per frame (1280*720*2/16).
REQ-004 SHALL have parameters BASE0 and BASE1, defaults 28'h0000000 and 28'h0400000, meaning byte base addresses of ping-pong frame buffers.
REQ-005 SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports vs_i, de_i, data_i, inputs, 1/1/16, meaning mixed-image vsync, pixel valid and RGB565 pixel.
REQ-008 SHALL have ports wr_req, output, 1, and wr_addr, output, 28, meaning burst request and byte start address.
REQ-009 SHALL have port wr_ack, input, 1, meaning burst request accepted.
REQ-010 SHALL have ports wr_valid, output, 1, and wr_data, output, 128, meaning the write beat; and port wr_ready, input, 1, meaning the beat is accepted.
REQ-011 SHALL have ports cur_buf, output, 1 (buffer being written), frame_done, output, 1 (one-cycle pulse) and overflow, output, 1 (sticky).

Function
REQ-012 SHALL sample vs_i in a register and detect a frame start as a 0->1 transition of that register.
REQ-013 SHALL pack 8 consecutive de_i pixels into one word, with the first pixel in bits [15:0] and the eighth in [127:112], and push the word one cycle after the eighth pixel.
REQ-014 SHALL run the FSM IDLE->REQ when FIFO count >= BURST_LEN, REQ->DATA on wr_ack, and DATA->IDLE after BURST_LEN beats.
REQ-015 SHALL, in REQ, hold wr_req=1 and wr_addr stable until wr_ack; wr_ack outside REQ SHALL be ignored.
REQ-016 SHALL, in DATA, drive wr_valid=1 with the FIFO head; a beat transfers when wr_valid&wr_ready; wr_data SHALL hold while wr_ready=0.
REQ-017 SHALL advance wr_addr by BURST_LEN*16 after each completed burst, wrapping modulo 2^28.
REQ-018 SHALL pulse frame_done for one cycle when the frame's written-word count reaches FRAME_WORDS, and SHALL write no further bursts for that frame.
REQ-019 SHALL, on frame start in IDLE or REQ, clear the packer and FIFO, drop wr_req, toggle cur_buf, and load wr_addr with BASE of the new cur_buf.
REQ-020 SHALL, on frame start in DATA, set flush_pending, ignore de_i, finish the burst, and perform the REQ-019 actions at burst end.
REQ-021 SHALL discard a partial word at frame start.
REQ-022 SHALL, when a push meets a full FIFO, drop the word and set overflow; overflow SHALL clear only on frame start.
REQ-023 SHALL give a simultaneous push and pop on a full FIFO a net-zero count change with no overflow.

Reset
REQ-024 SHALL, on rst_n=0, immediately set wr_req=0, wr_valid=0, wr_data=0, frame_done=0, overflow=0, cur_buf=1, wr_addr=BASE1, FSM=IDLE, FIFO empty, packer empty and flush_pending=0.
REQ-025 SHALL make the first frame start after reset select buffer 0 (BASE0).

Structure
REQ-026 SHALL place FSM state encoding and beat-byte constant (16) in shared package video_pkg.
REQ-027 SHALL instantiate one sub-module sync_fifo_128 (show-ahead, clear input, count output) for the word FIFO.

Verification
REQ-028 SHALL check: vs rise, 128 pixels 0..127 with wr_ready=1 and ack after 2 cycles -> one burst at 0x0000000, beat0 = pixels 7..0, 16 beats.
REQ-029 SHALL check: FRAME_WORDS=32, 256 pixels -> two bursts at 0x0 and 0x100, then frame_done pulse.
REQ-030 SHALL check: wr_ready toggling 1010 during DATA -> data held, exactly 16 beats, no data loss.
REQ-031 SHALL check: wr_ack withheld, 600 pixels pushed -> overflow=1 after word 65, cleared at next vs rise.
REQ-032 SHALL check: vs rise at beat 5 of a burst -> burst completes to 16 beats, then FIFO empty, cur_buf toggles, wr_addr=BASE1.
REQ-033 SHALL check: rst_n pulled low mid-burst -> wr_valid and wr_req fall asynchronously, and all REQ-024 values hold.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video capture path: burst-writer FSM state
// encoding and the byte width of one 128-bit memory beat.
package video_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int unsigned BEAT_BYTES = 16;

endpackage

// File: rtl/sync_fifo_128.sv
// Single-clock 128-bit word FIFO with show-ahead head output, synchronous
// clear and an occupancy count.
module sync_fifo_128 #(
  parameter int DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic [127:0]            push_data,
  input  logic                    pop,
  output logic [127:0]            head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (!do_push && do_pop)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/frame_burst_writer.sv
// Packs RGB565 pixels into 128-bit words and writes each frame as fixed-length
// bursts into alternating ping-pong frame buffers.
module frame_burst_writer
  import video_pkg::*;
#(
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_DEPTH  = 64,
  parameter int          FRAME_WORDS = 115200,
  parameter logic [27:0] BASE0       = 28'h0000000,
  parameter logic [27:0] BASE1       = 28'h0400000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vs_i,
  input  logic         de_i,
  input  logic [15:0]  data_i,
  output logic         wr_req,
  output logic [27:0]  wr_addr,
  input  logic         wr_ack,
  output logic         wr_valid,
  output logic [127:0] wr_data,
  input  logic         wr_ready,
  output logic         cur_buf,
  output logic         frame_done,
  output logic         overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam logic [27:0]   BURST_BYTES  = 28'(BURST_LEN * BEAT_BYTES);
  localparam logic [CW-1:0] BURST_THRESH = CW'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT    = BW'(BURST_LEN - 1);
  localparam logic [WW-1:0] LAST_WORD    = WW'(FRAME_WORDS - 1);

  logic [1:0]    state;
  logic          vs_r;
  logic          vs_r2;
  logic          frame_start;
  logic          flush_pending;
  logic [2:0]    pix_cnt;
  logic [111:0]  pack;
  logic          push_pending;
  logic [127:0]  push_word;
  logic [BW-1:0] beat_cnt;
  logic [WW-1:0] words_written;
  logic          frame_complete;
  logic [127:0]  fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          beat_xfer;
  logic          burst_end;
  logic          new_frame;
  logic          pixel_in;

  assign frame_start = vs_r & ~vs_r2;
  assign wr_valid    = (state == ST_DATA) && !fifo_empty;
  assign wr_data     = wr_valid ? fifo_head : '0;
  assign beat_xfer   = wr_valid && wr_ready;
  assign burst_end   = beat_xfer && (beat_cnt == LAST_BEAT);
  // A frame start during a burst is deferred until that burst has drained.
  assign new_frame   = (frame_start && (state != ST_DATA)) ||
                       (burst_end && (flush_pending || frame_start));
  assign pixel_in    = de_i && !flush_pending && !frame_start;
  assign fifo_push   = push_pending && !new_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r  <= 1'b0;
      vs_r2 <= 1'b0;
    end else begin
      vs_r  <= vs_i;
      vs_r2 <= vs_r;
    end
  end

  // The eighth pixel goes straight into the staged word, which is pushed next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt      <= '0;
      pack         <= '0;
      push_pending <= 1'b0;
      push_word    <= '0;
    end else if (frame_start || new_frame) begin
      pix_cnt      <= '0;
      push_pending <= 1'b0;
    end else begin
      push_pending <= 1'b0;
      if (pixel_in) begin
        if (pix_cnt == 3'd7) begin
          push_word    <= {data_i, pack};
          push_pending <= 1'b1;
        end else begin
          pack[{pix_cnt, 4'b0000} +: 16] <= data_i;
        end
        pix_cnt <= pix_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (frame_start)
      overflow <= 1'b0;
    else if (fifo_push && fifo_full && !beat_xfer)
      overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wr_req         <= 1'b0;
      wr_addr        <= BASE1;
      cur_buf        <= 1'b1;
      beat_cnt       <= '0;
      flush_pending  <= 1'b0;
      words_written  <= '0;
      frame_complete <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!frame_start && !frame_complete && (fifo_count >= BURST_THRESH)) begin
            state  <= ST_REQ;
            wr_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (frame_start) begin
            state  <= ST_IDLE;
            wr_req <= 1'b0;
          end else if (wr_ack) begin
            state  <= ST_DATA;
            wr_req <= 1'b0;
          end
        end
        ST_DATA: begin
          if (frame_start)
            flush_pending <= 1'b1;
          if (beat_xfer) begin
            beat_cnt      <= beat_cnt + BW'(1);
            words_written <= words_written + WW'(1);
            if (words_written == LAST_WORD) begin
              frame_done     <= 1'b1;
              frame_complete <= 1'b1;
            end
            if (burst_end) begin
              state   <= ST_IDLE;
              wr_addr <= wr_addr + BURST_BYTES;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (new_frame) begin
        cur_buf        <= ~cur_buf;
        wr_addr        <= cur_buf ? BASE0 : BASE1;
        wr_req         <= 1'b0;
        flush_pending  <= 1'b0;
        words_written  <= '0;
        frame_complete <= 1'b0;
      end
    end
  end

  sync_fifo_128 #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (new_frame),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (beat_xfer),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_frame_burst_writer.sv
// Directed self-checking bench for frame_burst_writer: burst addressing, packing,
// back-pressure, overflow, deferred frame flush and asynchronous reset.
module tb_frame_burst_writer;

  logic         clk;
  logic         rst_n;
  logic         vs_i;
  logic         de_i;
  logic [15:0]  data_i;
  logic         wr_req;
  logic [27:0]  wr_addr;
  logic         wr_ack;
  logic         wr_valid;
  logic [127:0] wr_data;
  logic         wr_ready;
  logic         cur_buf;
  logic         frame_done;
  logic         overflow;

  int tests = 0;
  int failures = 0;
  logic [127:0] beats[$];
  logic [27:0]  addrs[$];
  int done_count = 0;
  logic ack_en = 1'b0;
  logic ready_toggle = 1'b0;

  frame_burst_writer #(
    .BURST_LEN   (16),
    .FIFO_DEPTH  (64),
    .FRAME_WORDS (32),
    .BASE0       (28'h0000000),
    .BASE1       (28'h0400000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs_i       (vs_i),
    .de_i       (de_i),
    .data_i     (data_i),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_ack     (wr_ack),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .cur_buf    (cur_buf),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] packWord(input int first);
    logic [127:0] w;
    for (int j = 0; j < 8; j++)
      w[16*j +: 16] = 16'(first + j);
    return w;
  endfunction

  task automatic applyStimulus(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      de_i   = 1'b1;
      data_i = 16'(first + i);
    end
    @(posedge clk); #1;
    de_i = 1'b0;
  endtask

  task automatic vsRise();
    @(posedge clk); #1;
    vs_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vs_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic doReset();
    ack_en = 1'b0;
    ready_toggle = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    beats.delete();
    addrs.delete();
    done_count = 0;
  endtask

  task automatic waitBeats(input int n, input int limit, input string tag);
    int c = 0;
    while (beats.size() < n && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput(tag, 128'(beats.size() >= n), 128'd1);
  endtask

  // Memory-side responder: acks after wr_req has been seen for two cycles.
  initial begin : responder
    int req_wait;
    req_wait = 0;
    wr_ack   = 1'b0;
    wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      wr_ack = 1'b0;
      if (wr_req && ack_en) begin
        req_wait++;
        if (req_wait >= 2) begin
          wr_ack   = 1'b1;
          req_wait = 0;
        end
      end else begin
        req_wait = 0;
      end
      wr_ready = ready_toggle ? ~wr_ready : 1'b1;
    end
  end

  // Observes the write port between edges, recording beats and burst addresses.
  initial begin : monitor
    logic stalled;
    logic [127:0] held;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (stalled && wr_valid)
        checkOutput("data_hold_on_stall", wr_data, held);
      stalled = wr_valid && !wr_ready;
      held = wr_data;
      if (wr_valid && wr_ready) beats.push_back(wr_data);
      if (wr_req && wr_ack) addrs.push_back(wr_addr);
      if (frame_done) done_count++;
    end
  end

  initial begin
    rst_n  = 1'b1;
    vs_i   = 1'b0;
    de_i   = 1'b0;
    data_i = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_wr_req", 128'(wr_req), 128'd0);
    checkOutput("reset_wr_valid", 128'(wr_valid), 128'd0);
    checkOutput("reset_wr_data", wr_data, 128'd0);
    checkOutput("reset_frame_done", 128'(frame_done), 128'd0);
    checkOutput("reset_overflow", 128'(overflow), 128'd0);
    checkOutput("reset_cur_buf", 128'(cur_buf), 128'd1);
    checkOutput("reset_wr_addr", 128'(wr_addr), 128'h0400000);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    $display("[TB] single burst of 128 pixels");
    ack_en = 1'b1;
    vsRise();
    checkOutput("t1_cur_buf_first_frame", 128'(cur_buf), 128'd0);
    checkOutput("t1_wr_addr_base0", 128'(wr_addr), 128'h0000000);
    applyStimulus(128, 0);
    waitBeats(16, 100, "t1_burst_timeout");
    cycles(5);
    checkOutput("t1_beat_count", 128'(beats.size()), 128'd16);
    checkOutput("t1_burst_addr", 128'(addrs.size() > 0 ? addrs[0] : 28'hFFFFFFF), 128'h0000000);
    checkOutput("t1_beat0", beats.size() > 0 ? beats[0] : '0,
                128'h0007_0006_0005_0004_0003_0002_0001_0000);
    for (int k = 1; k < 16; k++)
      checkOutput($sformatf("t1_beat%0d", k), k < beats.size() ? beats[k] : '0, packWord(8*k));
    checkOutput("t1_addr_advance", 128'(wr_addr), 128'h0000100);
    checkOutput("t1_no_frame_done", 128'(done_count), 128'd0);

    $display("[TB] full frame of 32 words");
    doReset();
    ack_en = 1'b1;
    vsRise();
    applyStimulus(256, 0);
    waitBeats(32, 150, "t2_frame_timeout");
    cycles(5);
    checkOutput("t2_beat_count", 128'(beats.size()), 128'd32);
    checkOutput("t2_burst0_addr", 128'(addrs.size() > 0 ? addrs[0] : 28'hFFFFFFF), 128'h0000000);
    checkOutput("t2_burst1_addr", 128'(addrs.size() > 1 ? addrs[1] : 28'hFFFFFFF), 128'h0000100);
    checkOutput("t2_beat16", beats.size() > 16 ? beats[16] : '0, packWord(128));
    checkOutput("t2_beat31", beats.size() > 31 ? beats[31] : '0, packWord(248));
    checkOutput("t2_frame_done_pulses", 128'(done_count), 128'd1);
    checkOutput("t2_addr_after_frame", 128'(wr_addr), 128'h0000200);
    applyStimulus(128, 256);
    cycles(40);
    checkOutput("t2_no_extra_burst", 128'(beats.size()), 128'd32);
    checkOutput("t2_no_extra_req", 128'(wr_req), 128'd0);

    $display("[TB] burst under toggling wr_ready");
    doReset();
    ack_en = 1'b1;
    ready_toggle = 1'b1;
    vsRise();
    applyStimulus(128, 1000);
    waitBeats(16, 100, "t3_burst_timeout");
    cycles(10);
    checkOutput("t3_beat_count", 128'(beats.size()), 128'd16);
    for (int k = 0; k < 16; k++)
      checkOutput($sformatf("t3_beat%0d", k), k < beats.size() ? beats[k] : '0,
                  packWord(1000 + 8*k));
    ready_toggle = 1'b0;

    $display("[TB] overflow with ack withheld");
    doReset();
    vsRise();
    applyStimulus(512, 0);
    cycles(3);
    checkOutput("t4_full_no_overflow", 128'(overflow), 128'd0);
    checkOutput("t4_req_held", 128'(wr_req), 128'd1);
    checkOutput("t4_addr_stable", 128'(wr_addr), 128'h0000000);
    applyStimulus(8, 512);
    cycles(3);
    checkOutput("t4_overflow_set", 128'(overflow), 128'd1);
    applyStimulus(80, 520);
    cycles(3);
    checkOutput("t4_overflow_sticky", 128'(overflow), 128'd1);
    vsRise();
    checkOutput("t4_overflow_cleared", 128'(overflow), 128'd0);
    checkOutput("t4_req_dropped", 128'(wr_req), 128'd0);
    checkOutput("t4_cur_buf", 128'(cur_buf), 128'd1);
    checkOutput("t4_wr_addr_base1", 128'(wr_addr), 128'h0400000);

    $display("[TB] frame start in the middle of a burst");
    doReset();
    vsRise();
    applyStimulus(192, 0);
    cycles(2);
    ack_en = 1'b1;
    waitBeats(5, 50, "t5_beat5_timeout");
    vs_i = 1'b1;
    waitBeats(16, 50, "t5_burst_timeout");
    vs_i = 1'b0;
    cycles(5);
    checkOutput("t5_beat_count", 128'(beats.size()), 128'd16);
    checkOutput("t5_last_beat", beats.size() > 15 ? beats[15] : '0, packWord(120));
    checkOutput("t5_cur_buf", 128'(cur_buf), 128'd1);
    checkOutput("t5_wr_addr_base1", 128'(wr_addr), 128'h0400000);
    applyStimulus(64, 2000);
    cycles(30);
    checkOutput("t5_fifo_flushed_no_req", 128'(wr_req), 128'd0);
    checkOutput("t5_no_more_beats", 128'(beats.size()), 128'd16);

    $display("[TB] asynchronous reset mid-burst");
    doReset();
    ack_en = 1'b1;
    vsRise();
    applyStimulus(128, 0);
    waitBeats(3, 100, "t6_burst_timeout");
    checkOutput("t6_valid_before_reset", 128'(wr_valid), 128'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_wr_valid", 128'(wr_valid), 128'd0);
    checkOutput("t6_async_wr_data", wr_data, 128'd0);
    checkOutput("t6_async_cur_buf", 128'(cur_buf), 128'd1);
    checkOutput("t6_async_wr_addr", 128'(wr_addr), 128'h0400000);
    checkOutput("t6_async_overflow", 128'(overflow), 128'd0);
    cycles(2);
    rst_n = 1'b1;
    ack_en = 1'b0;
    cycles(1);
    vsRise();
    applyStimulus(128, 0);
    cycles(4);
    checkOutput("t6_req_before_reset", 128'(wr_req), 128'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_wr_req", 128'(wr_req), 128'd0);
    checkOutput("t6_async_frame_done", 128'(frame_done), 128'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    checkOutput("t6_fifo_empty_after_reset", 128'(wr_req), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
